alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The module SHALL have exactly one clock and one synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 in_valid input 1; upstream presents an instruction and its operands.
REQ-003 in_ready output 1; module accepts the presented instruction on this cycle.
REQ-004 instr input 16; WISC instruction word, opcode instr[15:11], func instr[1:0].
REQ-005 rs_data input 16; register-file read data for Rs.
REQ-006 rt_data input 16; register-file read data for Rt.
REQ-007 out_valid output 1; a decoded ALU command is presented.
REQ-008 out_ready input 1; downstream ALU stage consumes the presented command.
REQ-009 alu_a output 16; ALU first operand.
REQ-010 alu_b output 16; ALU second operand.
REQ-011 alu_op output 4; ALU operation code 0..14 (0 add, 1 sub B-A, 2 xor, 3 andn, 4 rol, 5 sll, 6 ror, 7 srl, 8 seq, 9 slt, 10 sle, 11 sco, 12 flip, 13 pass B, 14 move-bottom).
REQ-012 illegal output 1; the presented command came from an undecodable opcode.
REQ-013 illegal_cnt output 8; saturating illegal-instruction count; present only when ALU_CTRL_ILLEGAL_CNT_EN is defined.

Function
REQ-014 Handshake: a transfer SHALL occur on a cycle where valid and ready are both high; payload SHALL be held stable while valid is high and ready is low.
REQ-015 Decode SHALL feed a 2-entry FIFO output buffer; in_ready SHALL equal (count < 2), computed from registered count only.
REQ-016 Latency SHALL be 1 cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1 when the buffer is empty.
REQ-017 Simultaneous push and pop SHALL leave count unchanged and preserve order; pop at count 0 SHALL NOT occur since out_valid = (count != 0).
REQ-018 R-format: opcode 11011 -> alu_op = func (0..3); opcode 11010 -> alu_op = 4 + func; alu_a = rs_data, alu_b = rt_data.
REQ-019 Compare: opcodes 11100/11101/11110/11111 -> alu_op 8/9/10/11; alu_a = rs_data, alu_b = rt_data.
REQ-020 Immediate: 01000 ADDI op 0, 01001 SUBI op 1 with sign-extended instr[4:0]; 01010 XORI op 2, 01011 ANDNI op 3 with zero-extended instr[4:0]; alu_a = rs_data, alu_b = immediate.
REQ-021 Shift-immediate: 10100/10101/10110/10111 -> op 4/5/6/7; alu_b = zero-extended instr[3:0].
REQ-022 11001 BTR -> op 12, alu_a = rs_data; 11000 LBI -> op 13, alu_b = sign-extended instr[7:0]; 10010 SLBI -> op 14, alu_a = rs_data, alu_b = zero-extended instr[7:0].
REQ-023 Unused operand fields SHALL be driven 0.
REQ-024 Any other opcode SHALL enqueue an entry with alu_op 0, alu_a 0, alu_b 0, illegal 1.

Reset
REQ-025 While rst is high, count, FIFO pointers and illegal_cnt SHALL be 0, so out_valid = 0 and in_ready = 1 on the next cycle; alu_a, alu_b, alu_op and illegal SHALL read 0.
REQ-026 Reset mid-operation SHALL discard all buffered entries; no transfer SHALL be reported in the cycle rst is high.

Configuration
REQ-027 With ALU_CTRL_ILLEGAL_CNT_EN defined, illegal_cnt SHALL increment on each accepted illegal instruction and saturate at 255; without it, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-028 Opcode constants, the 4-bit ALU op encodings and the FIFO entry struct (a, b, op, illegal) SHALL live in shared package alu_pkg.
REQ-029 Decode SHALL be a combinational sub-module alu_ctrl_decode; the FIFO and counter SHALL reside in alu_ctrl.

Verification
REQ-030 ADD: instr 0xD800 (11011, func 00), rs 0x0003, rt 0x0004, out_ready 1 -> next cycle alu_op 0, a 0x0003, b 0x0004, illegal 0.
REQ-031 SUBI sign extend: instr 0x481F (01001, imm 11111), rs 0x0010 -> alu_op 1, a 0x0010, b 0xFFFF.
REQ-032 Backpressure: out_ready 0, push 3 instructions -> in_ready low after 2 accepted; release out_ready -> both pop in order, third accepted when count < 2.
REQ-033 Illegal: opcode 00110 -> illegal 1, op 0; with ALU_CTRL_ILLEGAL_CNT_EN, 300 illegal pushes -> illegal_cnt 255.
REQ-034 Reset with 2 entries buffered -> out_valid 0 and in_ready 1 the next cycle; subsequent LBI 0xC0F0 -> op 13, b 0xFFF0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, ALU op encodings and the
// decode-to-FIFO entry type for the ALU control block.
package alu_pkg;

  localparam logic [4:0] OPC_RALU  = 5'b11011;
  localparam logic [4:0] OPC_RSHF  = 5'b11010;
  localparam logic [4:0] OPC_ADDI  = 5'b01000;
  localparam logic [4:0] OPC_SUBI  = 5'b01001;
  localparam logic [4:0] OPC_XORI  = 5'b01010;
  localparam logic [4:0] OPC_ANDNI = 5'b01011;
  localparam logic [4:0] OPC_BTR   = 5'b11001;
  localparam logic [4:0] OPC_LBI   = 5'b11000;
  localparam logic [4:0] OPC_SLBI  = 5'b10010;

  // Group prefixes: shift-imm 101xx, compare 111xx
  localparam logic [2:0] GRP_SHI   = 3'b101;
  localparam logic [2:0] GRP_CMP   = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_ANDN = 4'd3,
    ALU_ROL  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_ROR  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SEQ  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLE  = 4'd10,
    ALU_SCO  = 4'd11,
    ALU_FLIP = 4'd12,
    ALU_PASS = 4'd13,
    ALU_MOVB = 4'd14
  } alu_op_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    alu_op_e     op;
    logic        illegal;
  } alu_ent_t;

  function automatic logic [15:0] sext5(
    input logic [4:0] v
  );
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext8(
    input logic [7:0] v
  );
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational WISC instruction decode into one
// ALU command entry (operands, op, illegal flag).
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [15:0] i_instr,
  input  logic [15:0] i_rs,
  input  logic [15:0] i_rt,
  output alu_ent_t    o_ent
);

  logic [4:0] w_opc;
  logic [1:0] w_func;
  logic [2:0] w_unused_bits;

  assign w_opc         = i_instr[15:11];
  assign w_func        = i_instr[1:0];
  assign w_unused_bits = i_instr[10:8];

  always_comb begin
    o_ent = '0;
    unique case (1'b1)
      (w_opc == OPC_RALU): begin
        o_ent.op = alu_op_e'({2'b00, w_func});
        o_ent.a  = i_rs;
        o_ent.b  = i_rt;
      end
      (w_opc == OPC_RSHF): begin
        o_ent.op = alu_op_e'({2'b01, w_func});
        o_ent.a  = i_rs;
        o_ent.b  = i_rt;
      end
      (w_opc[4:2] == GRP_CMP): begin
        o_ent.op = alu_op_e'({2'b10, w_opc[1:0]});
        o_ent.a  = i_rs;
        o_ent.b  = i_rt;
      end
      (w_opc == OPC_ADDI): begin
        o_ent.op = ALU_ADD;
        o_ent.a  = i_rs;
        o_ent.b  = sext5(i_instr[4:0]);
      end
      (w_opc == OPC_SUBI): begin
        o_ent.op = ALU_SUB;
        o_ent.a  = i_rs;
        o_ent.b  = sext5(i_instr[4:0]);
      end
      (w_opc == OPC_XORI): begin
        o_ent.op = ALU_XOR;
        o_ent.a  = i_rs;
        o_ent.b  = {11'd0, i_instr[4:0]};
      end
      (w_opc == OPC_ANDNI): begin
        o_ent.op = ALU_ANDN;
        o_ent.a  = i_rs;
        o_ent.b  = {11'd0, i_instr[4:0]};
      end
      (w_opc[4:2] == GRP_SHI): begin
        o_ent.op = alu_op_e'({2'b01, w_opc[1:0]});
        o_ent.a  = i_rs;
        o_ent.b  = {12'd0, i_instr[3:0]};
      end
      (w_opc == OPC_BTR): begin
        o_ent.op = ALU_FLIP;
        o_ent.a  = i_rs;
      end
      (w_opc == OPC_LBI): begin
        o_ent.op = ALU_PASS;
        o_ent.b  = sext8(i_instr[7:0]);
      end
      (w_opc == OPC_SLBI): begin
        o_ent.op = ALU_MOVB;
        o_ent.a  = i_rs;
        o_ent.b  = {8'd0, i_instr[7:0]};
      end
      default: begin
        o_ent.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU control: decode into a 2-entry output FIFO.
// ALU_CTRL_ILLEGAL_CNT_EN adds a saturating illegal_cnt.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  output logic [7:0]  illegal_cnt,
`endif
  output logic        illegal
);

  alu_ent_t   w_dec;
  alu_ent_t   w_out;
  alu_ent_t   r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  alu_ctrl_decode u_dec (
    .i_instr (instr),
    .i_rs    (rs_data),
    .i_rt    (rt_data),
    .o_ent   (w_dec)
  );

  // rst gating hides stale state during the reset cycle
  assign in_ready  = ~rst & (r_count < 2'd2);
  assign out_valid = ~rst & (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign w_out   = out_valid ? r_mem[r_rptr] : '0;
  assign alu_a   = w_out.a;
  assign alu_b   = w_out.b;
  assign alu_op  = w_out.op;
  assign illegal = w_out.illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_dec;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [7:0] r_ill_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ill_cnt <= 8'd0;
    end else if (w_push && w_dec.illegal
                 && r_ill_cnt != 8'hFF) begin
      r_ill_cnt <= r_ill_cnt + 8'd1;
    end
  end

  assign illegal_cnt = r_ill_cnt;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized bench for alu_ctrl against a queue model
// of the decode table and 2-deep buffer.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic        illegal;
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [7:0]  illegal_cnt;
`endif

  alu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    .illegal_cnt (illegal_cnt),
`endif
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   ref_cnt = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  function automatic exp_t ref_dec(
    input logic [15:0] ins,
    input logic [15:0] rs,
    input logic [15:0] rt
  );
    exp_t e;
    int   opc;
    int   fn;
    int   s5;
    int   s8;
    opc = int'(ins[15:11]);
    fn  = int'(ins[1:0]);
    s5  = int'(ins[4:0]);
    if (s5 >= 16) s5 = s5 - 32;
    s8  = int'(ins[7:0]);
    if (s8 >= 128) s8 = s8 - 256;
    e = '{a: 16'd0, b: 16'd0, op: 4'd0, ill: 1'b0};
    if (opc == 27) begin
      e.op = 4'(fn); e.a = rs; e.b = rt;
    end else if (opc == 26) begin
      e.op = 4'(4 + fn); e.a = rs; e.b = rt;
    end else if (opc >= 28) begin
      e.op = 4'(8 + opc - 28); e.a = rs; e.b = rt;
    end else if (opc >= 8 && opc <= 11) begin
      e.op = 4'(opc - 8); e.a = rs;
      e.b = (opc <= 9) ? 16'(s5) : 16'(ins[4:0]);
    end else if (opc >= 20 && opc <= 23) begin
      e.op = 4'(opc - 16); e.a = rs;
      e.b = 16'(ins[3:0]);
    end else if (opc == 25) begin
      e.op = 4'd12; e.a = rs;
    end else if (opc == 24) begin
      e.op = 4'd13; e.b = 16'(s8);
    end else if (opc == 18) begin
      e.op = 4'd14; e.a = rs; e.b = 16'(ins[7:0]);
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic compare();
    exp_t e;
    logic ev;
    ev = !rst && (q.size() != 0);
    e  = '{a: 16'd0, b: 16'd0, op: 4'd0, ill: 1'b0};
    if (ev) e = q[0];
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready),
        32'(!rst && q.size() < 2));
    chk("alu_a", 32'(alu_a), 32'(e.a));
    chk("alu_b", 32'(alu_b), 32'(e.b));
    chk("alu_op", 32'(alu_op), 32'(e.op));
    chk("illegal", 32'(illegal), 32'(e.ill));
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    chk("illegal_cnt", 32'(illegal_cnt), 32'(ref_cnt));
`endif
  endtask

  task automatic cycle(
    input logic        r,
    input logic        v,
    input logic [15:0] ins,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        ordy
  );
    int   sz;
    exp_t e;
    rst = r; in_valid = v; instr = ins;
    rs_data = a; rt_data = b; out_ready = ordy;
    sz = q.size();
    @(posedge clk);
    if (r) begin
      q.delete();
      ref_cnt = 0;
    end else begin
      if (sz != 0 && ordy) e = q.pop_front();
      if (v && sz < 2) begin
        e = ref_dec(ins, a, b);
        q.push_back(e);
        if (e.ill && ref_cnt < 255) ref_cnt++;
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
  endtask

  initial begin
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    idle(1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    cycle(1'b0, 1'b1, 16'hD800, 16'h0003, 16'h0004, 1'b1);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op", 32'(alu_op), 32'd0);
    chk("add_a", 32'(alu_a), 32'h0003);
    chk("add_b", 32'(alu_b), 32'h0004);
    chk("add_ill", 32'(illegal), 32'd0);
    idle(2);

    cycle(1'b0, 1'b1, 16'h481F, 16'h0010, 16'h0000, 1'b1);
    chk("subi_op", 32'(alu_op), 32'd1);
    chk("subi_a", 32'(alu_a), 32'h0010);
    chk("subi_b", 32'(alu_b), 32'hFFFF);
    idle(2);

    cycle(1'b0, 1'b1, 16'hD801, 16'h0011, 16'h0022, 1'b0);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    cycle(1'b0, 1'b1, 16'hD802, 16'h0033, 16'h0044, 1'b0);
    chk("bp_rdy2", 32'(in_ready), 32'd0);
    cycle(1'b0, 1'b1, 16'hD803, 16'h0055, 16'h0066, 1'b0);
    chk("bp_hold_a", 32'(alu_a), 32'h0011);
    cycle(1'b0, 1'b1, 16'hD803, 16'h0055, 16'h0066, 1'b1);
    chk("bp_pop2_a", 32'(alu_a), 32'h0033);
    chk("bp_pop2_op", 32'(alu_op), 32'd2);
    cycle(1'b0, 1'b1, 16'hD803, 16'h0055, 16'h0066, 1'b1);
    chk("bp_third_a", 32'(alu_a), 32'h0055);
    chk("bp_third_op", 32'(alu_op), 32'd3);
    idle(2);

    cycle(1'b0, 1'b1, 16'h3000, 16'h1234, 16'h5678, 1'b1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_op", 32'(alu_op), 32'd0);
    chk("ill_a", 32'(alu_a), 32'd0);
    idle(2);

    cycle(1'b0, 1'b1, 16'hD800, 16'h0001, 16'h0002, 1'b0);
    cycle(1'b0, 1'b1, 16'hD800, 16'h0003, 16'h0004, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("rst_mid_rdy", 32'(in_ready), 32'd1);
    chk("rst_mid_empty", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b1, 16'hC0F0, 16'h1234, 16'h5678, 1'b1);
    chk("lbi_op", 32'(alu_op), 32'd13);
    chk("lbi_b", 32'(alu_b), 32'hFFF0);
    chk("lbi_a", 32'(alu_a), 32'd0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0),
            1'($urandom_range(3) != 0),
            16'($urandom), 16'($urandom),
            16'($urandom),
            1'($urandom_range(2) != 0));
    end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 300; i++)
      cycle(1'b0, 1'b1, 16'h3000, 16'h0, 16'h0, 1'b1);
    chk("ill_cnt_sat", 32'(illegal_cnt), 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
